// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared constants and width helper for the 1 us timer
package timer_pkg;

    localparam int DEFAULT_CLK_MHZ = 25;

    // Counter width for a modulo-x counter, never narrower than one bit.
    function automatic int cnt_width(input int x);
        return (x > 1) ? $clog2(x) : 1;
    endfunction

endpackage

// File: rtl/us_prescaler.sv
// rtl/us_prescaler.sv - divides the system clock down to a 1 us strobe
//
// Ports:
//   clk     - system clock, rising edge
//   reset   - asynchronous active-low reset
//   en      - count enable; the prescaler holds while low
//   us_tick - combinational one-cycle strobe on the last enabled cycle of each microsecond
//
// Optional macro TIMER_1US_ASSERT_EN compiles in a range check on the prescaler.
module us_prescaler
    import timer_pkg::*;
#(
    parameter int CLK_MHZ = DEFAULT_CLK_MHZ
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic us_tick
);

    localparam int              PW      = cnt_width(CLK_MHZ);
    localparam logic [PW-1:0]   PRE_MAX = PW'(CLK_MHZ - 1);

    logic [PW-1:0] pre;
    logic          pre_wrap;

    assign pre_wrap = (pre == PRE_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre <= '0;
        end else if (en) begin
            pre <= pre_wrap ? '0 : pre + 1'b1;
        end
    end

    // Qualified by en so a paused timer never advances the microsecond counter.
    assign us_tick = en & pre_wrap;

`ifdef TIMER_1US_ASSERT_EN
    a_pre_range: assert property (@(posedge clk) disable iff (!reset)
        int'(pre) < CLK_MHZ);
`endif

endmodule

// File: rtl/timer_1us.sv
// rtl/timer_1us.sv - periodic one-cycle tick every PERIOD microseconds
//
// Parameters:
//   PERIOD  - tick period in microseconds (1 .. 2^24-1)
//   CLK_MHZ - clock cycles per microsecond (>= 1)
// Ports:
//   clk_25MHz - system clock, rising edge
//   reset     - asynchronous active-low reset
//   en        - count enable; a low en pauses both counters without restarting them
//   q         - registered tick, high for one cycle per period (continuously when
//               PERIOD*CLK_MHZ == 1 and enabled)
//
// Optional macro TIMER_1US_ASSERT_EN compiles in counter-range and pulse-shape assertions.
module timer_1us
    import timer_pkg::*;
#(
    parameter int PERIOD  = 1000,
    parameter int CLK_MHZ = DEFAULT_CLK_MHZ
) (
    input  logic clk_25MHz,
    input  logic reset,
    input  logic en,
    output logic q
);

    localparam int            UW     = cnt_width(PERIOD);
    localparam logic [UW-1:0] US_MAX = UW'(PERIOD - 1);

    logic          us_tick;
    logic [UW-1:0] us;
    logic          us_wrap;

    us_prescaler #(
        .CLK_MHZ (CLK_MHZ)
    ) u_prescaler (
        .clk     (clk_25MHz),
        .reset   (reset),
        .en      (en),
        .us_tick (us_tick)
    );

    assign us_wrap = (us == US_MAX);

    always_ff @(posedge clk_25MHz or negedge reset) begin
        if (!reset) begin
            us <= '0;
            q  <= 1'b0;
        end else begin
            if (us_tick) begin
                us <= us_wrap ? '0 : us + 1'b1;
            end
            // us_tick already carries en, so disabled edges clear q here too.
            q <= us_tick & us_wrap;
        end
    end

`ifdef TIMER_1US_ASSERT_EN
    a_us_range: assert property (@(posedge clk_25MHz) disable iff (!reset)
        int'(us) < PERIOD);

    a_q_after_en: assert property (@(posedge clk_25MHz) disable iff (!reset)
        $rose(q) |-> $past(en));

    if (PERIOD * CLK_MHZ > 1) begin : g_single_cycle
        a_q_one_cycle: assert property (@(posedge clk_25MHz) disable iff (!reset)
            q |=> !q);
    end
`endif

endmodule

// File: tb/tb_timer_1us.sv
// tb/tb_timer_1us.sv - randomized scoreboard bench for timer_1us over several parameter sets
module tb_timer_1us;

    localparam int NDUT = 4;

    logic       clk;
    logic       reset;
    logic       en;
    logic [3:0] qv;

    // Edges per period for each instance: PERIOD*CLK_MHZ.
    int         ns [NDUT] = '{100, 1, 6, 500};
    int         cnt[NDUT];
    logic [3:0] exp_q[$];
    logic [3:0] last_exp;

    int n_checks = 0;
    int n_fail   = 0;

    timer_1us #(.PERIOD(4),  .CLK_MHZ(25)) dut_a (.clk_25MHz(clk), .reset(reset), .en(en), .q(qv[0]));
    timer_1us #(.PERIOD(1),  .CLK_MHZ(1))  dut_b (.clk_25MHz(clk), .reset(reset), .en(en), .q(qv[1]));
    timer_1us #(.PERIOD(3),  .CLK_MHZ(2))  dut_c (.clk_25MHz(clk), .reset(reset), .en(en), .q(qv[2]));
    timer_1us #(.PERIOD(20), .CLK_MHZ(25)) dut_d (.clk_25MHz(clk), .reset(reset), .en(en), .q(qv[3]));

    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: a pulse follows every N-th enabled edge since the last
    // pulse or reset; reset and disabled edges give q=0.
    task automatic step(input logic en_v, input logic rst_v);
        logic [3:0] e;
        @(negedge clk);
        en    = en_v;
        reset = rst_v;
        for (int i = 0; i < NDUT; i++) begin
            e[i] = 1'b0;
            if (!rst_v) begin
                cnt[i] = 0;
            end else if (en_v) begin
                cnt[i]++;
                if (cnt[i] == ns[i]) begin
                    e[i]   = 1'b1;
                    cnt[i] = 0;
                end
            end
        end
        exp_q.push_back(e);
        last_exp = e;
        @(posedge clk);
    endtask

    // Pull reset low between edges and confirm everything clears without a clock.
    task automatic async_reset(input string tag);
        #10 reset = 1'b0;
        for (int i = 0; i < NDUT; i++) cnt[i] = 0;
        #1;
        for (int i = 0; i < NDUT; i++) check($sformatf("%s_q%0d", tag, i), int'(qv[i]), 0);
        check({tag, "_pre_a"}, int'(dut_a.u_prescaler.pre), 0);
        check({tag, "_us_a"},  int'(dut_a.us), 0);
    endtask

    // Monitor: one expected vector per clock edge, compared after the edge settles.
    initial begin
        logic [3:0] e;
        forever begin
            @(posedge clk);
            #5;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int i = 0; i < NDUT; i++)
                    check($sformatf("q%0d", i), int'(qv[i]), int'(e[i]));
            end
        end
    end

    initial begin
        bit found;
        for (int i = 0; i < NDUT; i++) cnt[i] = 0;
        en    = 1'b1;
        reset = 1'b0;
        #1;
        for (int i = 0; i < NDUT; i++) check($sformatf("rst_q%0d", i), int'(qv[i]), 0);

        // Held reset, then enable pause: first A pulse after edge 137.
        repeat (3) step(1'b1, 1'b0);
        repeat (50) step(1'b1, 1'b1);
        repeat (37) step(1'b0, 1'b1);
        repeat (250) step(1'b1, 1'b1);

        // Async reset mid-count between edges 70 and 71.
        async_reset("arst0");
        repeat (2) step(1'b1, 1'b0);
        repeat (70) step(1'b1, 1'b1);
        async_reset("arst1");
        repeat (2) step(1'b1, 1'b0);
        repeat (150) step(1'b1, 1'b1);

        // Random enable patterns.
        repeat (600) step(($urandom_range(0, 3) != 0), 1'b1);

        // Reset while A's pulse is high.
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            step(1'b1, 1'b1);
            if (last_exp[0]) found = 1'b1;
        end
        check("pulse_found", int'(found), 1);
        #6;
        check("pulse_high_before_rst", int'(qv[0]), int'(found));
        #4 reset = 1'b0;
        for (int i = 0; i < NDUT; i++) cnt[i] = 0;
        #1;
        check("pulse_rst_q0", int'(qv[0]), 0);
        repeat (2) step(1'b1, 1'b0);
        repeat (300) step(($urandom_range(0, 4) != 0), 1'b1);

        @(posedge clk);
        #10;
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
